// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the PC sequencer and its driver/consumer.
interface pc_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             jump_en;
  logic [WIDTH-1:0] jump_addr;
  logic             halt;
  logic             fetch_ready;
  logic [WIDTH-1:0] pc;
  logic             pc_valid;
  logic             jump_pending;

  modport master (
    output jump_en, jump_addr, halt, fetch_ready,
    input  pc, pc_valid, jump_pending
  );

  modport slave (
    input  jump_en, jump_addr, halt, fetch_ready,
    output pc, pc_valid, jump_pending
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fixed-step advance, jump redirects, halt, and a
// valid/ready offer of the current PC to the fetch stage.
module pc_sequencer #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      STEP         = 1
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.slave bus
);
  localparam logic [WIDTH-1:0] L_STEP = WIDTH'(STEP);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_tgt;
  logic             r_pc_valid;
  logic             r_pend;

  logic             w_accept;
  logic [WIDTH-1:0] w_adv_pc;
  logic [WIDTH-1:0] w_halt_pc;

  assign w_accept  = r_pc_valid & bus.fetch_ready;
  // Fresh jump beats a latched target, which beats the sequential step.
  assign w_adv_pc  = bus.jump_en ? bus.jump_addr :
                     r_pend      ? r_tgt         : r_pc + L_STEP;
  // Entering HALTED without an accept: fold any redirect into pc now.
  assign w_halt_pc = bus.jump_en ? bus.jump_addr :
                     r_pend      ? r_tgt         : r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= BOOT;
      r_pc       <= RESET_VECTOR;
      r_tgt      <= '0;
      r_pc_valid <= 1'b0;
      r_pend     <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          if (bus.jump_en) r_pc <= bus.jump_addr;
          r_pend     <= 1'b0;
          r_state    <= bus.halt ? HALTED : RUN;
          r_pc_valid <= ~bus.halt;
        end
        RUN: begin
          if (w_accept) begin
            r_pc   <= w_adv_pc;
            r_pend <= 1'b0;
          end else if (bus.halt) begin
            r_pc   <= w_halt_pc;
            r_pend <= 1'b0;
          end else if (bus.jump_en) begin
            r_tgt  <= bus.jump_addr;
            r_pend <= 1'b1;
          end
          if (bus.halt) begin
            r_state    <= HALTED;
            r_pc_valid <= 1'b0;
          end
        end
        HALTED: begin
          if (bus.jump_en) begin
            r_pc   <= bus.jump_addr;
            r_pend <= 1'b0;
          end
          if (!bus.halt) begin
            r_state    <= RUN;
            r_pc_valid <= 1'b1;
          end
        end
        default: begin
          r_state    <= BOOT;
          r_pc_valid <= 1'b0;
          r_pend     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc           = r_pc;
  assign bus.pc_valid     = r_pc_valid;
  assign bus.jump_pending = r_pend;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (STEP=1, STEP=4) share stimulus and
// are checked every cycle against a behavioural model, plus literal checks.
module tb_pc_sequencer;
  localparam int W = 16;
  localparam logic [W-1:0] RV = 16'h0100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(W)) ifa ();
  pc_sequencer_if #(.WIDTH(W)) ifb ();

  assign ifb.jump_en     = ifa.jump_en;
  assign ifb.jump_addr   = ifa.jump_addr;
  assign ifb.halt        = ifa.halt;
  assign ifb.fetch_ready = ifa.fetch_ready;

  pc_sequencer #(.WIDTH(W), .RESET_VECTOR(RV), .STEP(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  pc_sequencer #(.WIDTH(W), .RESET_VECTOR(RV), .STEP(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: what the fetch side should observe, derived from the rules.
  typedef struct packed {
    logic [W-1:0] pc;
    logic         valid;
    logic         pend;
    logic [W-1:0] tgt;
    logic         boot;
  } mdl_t;

  mdl_t ma = '0;
  mdl_t mb = '0;

  function automatic mdl_t nxt(input mdl_t m, input int step, input logic r,
                               input logic je, input logic [W-1:0] ja,
                               input logic h, input logic rdy);
    mdl_t n;
    bit acc;
    n = m;
    if (r) begin
      n = '{pc: RV, valid: 1'b0, pend: 1'b0, tgt: '0, boot: 1'b1};
      return n;
    end
    if (m.boot) begin
      n.boot = 1'b0;
      if (je) n.pc = ja;
      n.valid = !h;
      return n;
    end
    if (m.valid) begin
      acc = rdy;
      if (acc) begin
        if (je)          n.pc = ja;
        else if (m.pend) n.pc = m.tgt;
        else             n.pc = W'((int'(m.pc) + step) % 65536);
        n.pend = 1'b0;
      end else if (je) begin
        n.pend = 1'b1;
        n.tgt  = ja;
      end
      if (h) begin
        n.valid = 1'b0;
        if (!acc && n.pend) n.pc = n.tgt;
        n.pend = 1'b0;
      end
    end else begin
      if (je) begin
        n.pc   = ja;
        n.pend = 1'b0;
      end
      n.valid = !h;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ma <= nxt(ma, 1, rst, ifa.jump_en, ifa.jump_addr, ifa.halt, ifa.fetch_ready);
    mb <= nxt(mb, 4, rst, ifa.jump_en, ifa.jump_addr, ifa.halt, ifa.fetch_ready);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_a_pc",    32'(ifa.pc),           32'(ma.pc));
      chk("model_a_valid", 32'(ifa.pc_valid),     32'(ma.valid));
      chk("model_a_pend",  32'(ifa.jump_pending), 32'(ma.pend));
      chk("model_b_pc",    32'(ifb.pc),           32'(mb.pc));
      chk("model_b_valid", 32'(ifb.pc_valid),     32'(mb.valid));
      chk("model_b_pend",  32'(ifb.jump_pending), 32'(mb.pend));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic je, input logic [W-1:0] ja, input logic h, input logic rdy);
    ifa.jump_en     = je;
    ifa.jump_addr   = ja;
    ifa.halt        = h;
    ifa.fetch_ready = rdy;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_pc",    32'(ifa.pc), 32'h0100);
    chk("reset_valid", 32'(ifa.pc_valid), 0);
    chk("reset_pend",  32'(ifa.jump_pending), 0);

    // Reset then run
    rst = 1'b0;
    tick();
    chk("first_valid", 32'(ifa.pc_valid), 1);
    chk("first_pc",    32'(ifa.pc), 32'h0100);
    tick();
    chk("seq_pc1", 32'(ifa.pc), 32'h0101);
    repeat (4) tick();
    chk("seq_pc5", 32'(ifa.pc), 32'h0105);

    // Backpressure
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_pc_hold",    32'(ifa.pc), 32'h0105);
      chk("bp_valid_hold", 32'(ifa.pc_valid), 1);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    chk("bp_release_pc", 32'(ifa.pc), 32'h0106);

    // Jump under backpressure, newest target wins
    drive(1'b1, 16'h2000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h3000, 1'b0, 1'b0);
    tick();
    chk("jbp_pend",    32'(ifa.jump_pending), 1);
    chk("jbp_pc_hold", 32'(ifa.pc), 32'h0106);
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    chk("jbp_pc",      32'(ifa.pc), 32'h3000);
    chk("jbp_pend_clr", 32'(ifa.jump_pending), 0);

    // Pending target vs fresh jump at accept: fresh jump wins
    drive(1'b1, 16'h0A00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0B00, 1'b0, 1'b1);
    tick();
    chk("jwin_pc", 32'(ifa.pc), 32'h0B00);

    // Wrap: both at 0xFFFE, then step by 1 and by 4
    drive(1'b1, 16'hFFFE, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    chk("wrap_a_ffff", 32'(ifa.pc), 32'hFFFF);
    chk("wrap_b_step4", 32'(ifb.pc), 32'h0002);
    tick();
    chk("wrap_a_zero",  32'(ifa.pc), 32'h0000);
    chk("wrap_a_valid", 32'(ifa.pc_valid), 1);

    // Halt with accept, then jump while halted
    drive(1'b1, 16'h0040, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    chk("halt_pc",    32'(ifa.pc), 32'h0041);
    chk("halt_valid", 32'(ifa.pc_valid), 0);
    drive(1'b1, 16'h0800, 1'b1, 1'b1);
    tick();
    chk("halt_jump_pc", 32'(ifa.pc), 32'h0800);
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    chk("halt_hold_valid", 32'(ifa.pc_valid), 0);
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    chk("unhalt_valid", 32'(ifa.pc_valid), 1);
    chk("unhalt_pc",    32'(ifa.pc), 32'h0800);

    // Pending target applied on halt entry
    drive(1'b1, 16'h0500, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk("halt_pend_pc",  32'(ifa.pc), 32'h0500);
    chk("halt_pend_clr", 32'(ifa.jump_pending), 0);
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();

    // Reset mid-operation with a pending redirect
    drive(1'b1, 16'h1234, 1'b0, 1'b0);
    tick();
    chk("pre_rst_pend", 32'(ifa.jump_pending), 1);
    drive(1'b0, '0, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    chk("mid_rst_pc",    32'(ifa.pc), 32'h0100);
    chk("mid_rst_valid", 32'(ifa.pc_valid), 0);
    chk("mid_rst_pend",  32'(ifa.jump_pending), 0);

    // Jump during BOOT loads pc directly
    rst = 1'b0;
    drive(1'b1, 16'h0700, 1'b0, 1'b0);
    tick();
    chk("boot_jump_pc",    32'(ifa.pc), 32'h0700);
    chk("boot_jump_valid", 32'(ifa.pc_valid), 1);

    // Mixed traffic, checked cycle-by-cycle against the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive(($urandom_range(0, 3) == 0), 16'($urandom), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) != 0));
      tick();
    end

    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
